// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I-subset control FSM; 3-5 cycles per instruction with mem_ready always high.
// Memory states stall on mem_ready; MAX_WAIT consecutive unready cycles trap with cause 10.
module multicycle_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       mem_addr_sel,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_control,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic       instr_done,
  output logic [1:0] trap_cause,
  output logic [3:0] state_dbg
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_EXEC_R = 4'd3;
  localparam logic [3:0] S_EXEC_I = 4'd4;
  localparam logic [3:0] S_ADDR   = 4'd5;
  localparam logic [3:0] S_MEM_RD = 4'd6;
  localparam logic [3:0] S_MEM_WR = 4'd7;
  localparam logic [3:0] S_WB_ALU = 4'd8;
  localparam logic [3:0] S_WB_MEM = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JAL    = 4'd11;
  localparam logic [3:0] S_TRAP   = 4'd15;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  logic [3:0]        state, state_nx;
  logic [1:0]        cause_nx;
  logic [WAIT_W-1:0] wait_cnt;
  logic              in_mem_state;
  logic              timeout;
  logic              retire;
  logic              alu_ok;
  logic [3:0]        alu_op;

  assign in_mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  // This cycle would be the MAX_WAIT-th consecutive unready cycle.
  assign timeout = in_mem_state && !mem_ready && (wait_cnt == WAIT_W'(MAX_WAIT - 1));

  // funct7_5 only selects SUB for register-register ops; immediates always ADD.
  always_comb begin
    alu_ok = 1'b1;
    alu_op = ALU_ADD;
    case (funct3)
      3'b000:  alu_op = (state == S_EXEC_R && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_op = ALU_AND;
      3'b110:  alu_op = ALU_OR;
      3'b100:  alu_op = ALU_XOR;
      3'b010:  alu_op = ALU_SLT;
      default: begin
        alu_ok = 1'b0;
        alu_op = ALU_AND;
      end
    endcase
  end

  always_comb begin
    state_nx = state;
    cause_nx = trap_cause;
    retire   = 1'b0;
    case (state)
      S_IDLE:   if (run) state_nx = S_FETCH;
      S_FETCH: begin
        if (mem_ready) state_nx = S_DECODE;
        else if (timeout) begin
          state_nx = S_TRAP;
          cause_nx = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R:              state_nx = S_EXEC_R;
          OP_I:              state_nx = S_EXEC_I;
          OP_LOAD, OP_STORE: state_nx = S_ADDR;
          OP_JAL:            state_nx = S_JAL;
          default:           state_nx = S_TRAP;
        endcase
        if (opcode == OP_BR && (funct3 == 3'b000 || funct3 == 3'b001)) state_nx = S_BRANCH;
        if (state_nx == S_TRAP) cause_nx = CAUSE_ILLEGAL;
      end
      S_EXEC_R, S_EXEC_I: begin
        if (alu_ok) state_nx = S_WB_ALU;
        else begin
          state_nx = S_TRAP;
          cause_nx = CAUSE_ILLEGAL;
        end
      end
      S_ADDR:   state_nx = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready) state_nx = S_WB_MEM;
        else if (timeout) begin
          state_nx = S_TRAP;
          cause_nx = CAUSE_TIMEOUT;
        end
      end
      S_MEM_WR: begin
        if (mem_ready) retire = 1'b1;
        else if (timeout) begin
          state_nx = S_TRAP;
          cause_nx = CAUSE_TIMEOUT;
        end
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL: retire = 1'b1;
      S_TRAP:   state_nx = S_TRAP;
      default:  state_nx = S_IDLE;
    endcase
    if (retire) state_nx = run ? S_FETCH : S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      trap_cause <= 2'b00;
    end else begin
      state      <= state_nx;
      trap_cause <= cause_nx;
      if (!in_mem_state || mem_ready || state_nx != state) wait_cnt <= '0;
      else wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  always_comb begin
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    ir_write     = 1'b0;
    mem_addr_sel = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    alu_control  = ALU_AND;
    reg_write    = 1'b0;
    mem_to_reg   = 2'b00;
    case (state)
      S_FETCH: begin
        mem_read    = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        ir_write    = mem_ready;
        pc_write    = mem_ready;
      end
      S_DECODE: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
      end
      S_EXEC_R: begin
        alu_src_a   = 2'b01;
        alu_control = alu_op;
      end
      S_EXEC_I: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        alu_control = alu_op;
      end
      S_ADDR: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
      end
      S_MEM_RD: begin
        mem_read     = 1'b1;
        mem_addr_sel = 1'b1;
      end
      S_MEM_WR: begin
        mem_write    = 1'b1;
        mem_addr_sel = 1'b1;
      end
      S_WB_ALU: reg_write = 1'b1;
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b01;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        pc_write    = (funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero);
      end
      S_JAL: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b10;
        pc_write   = 1'b1;
        pc_src     = 2'b10;
      end
      default: ;
    endcase
  end

  assign instr_done = retire;
  assign state_dbg  = state;

endmodule
